// File: rtl/abs_diff_pkg.sv
// abs_diff_pkg: literal indexing helpers and monitor counter constants for abs_diff_sop_pipe
package abs_diff_pkg;
  localparam int LIT_PER_BIT = 2;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;
  function automatic int lit_idx(input int p, input int i, input int width);
    return p * LIT_PER_BIT * width + i;
  endfunction
endpackage

// File: rtl/abs_diff_sop_pipe_sop_plane.sv
// sop_plane: parametrised AND plane on x and OR plane on registered products
module sop_plane
  import abs_diff_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int OUT_W = 2,
  parameter int NPROD = 2,
  parameter logic [NPROD*2*WIDTH-1:0] LPOS = '0,
  parameter logic [NPROD*2*WIDTH-1:0] LNEG = '0,
  parameter logic [NPROD*OUT_W-1:0] ACT = '0
) (
  input  logic [2*WIDTH-1:0] x,
  input  logic [NPROD-1:0]   prod_q,
  output logic [NPROD-1:0]   prod,
  output logic [OUT_W-1:0]   y
);
  // a bit present in both LPOS and LNEG forces its product to 0 naturally
  always_comb begin
    prod = '1;
    y = '0;
    for (int p = 0; p < NPROD; p++)
      for (int i = 0; i < 2*WIDTH; i++)
        prod[p] = prod[p] & (x[i] | ~LPOS[lit_idx(p, i, WIDTH)]) & (~x[i] | ~LNEG[lit_idx(p, i, WIDTH)]);
    for (int p = 0; p < NPROD; p++)
      for (int j = 0; j < OUT_W; j++)
        y[j] = y[j] | (prod_q[p] & ACT[p*OUT_W+j]);
  end
endmodule

// File: rtl/abs_diff_sop_pipe.sv
// abs_diff_sop_pipe: 2-stage SOP approximate |a-b| pipeline; ABS_DIFF_ERR_MON_EN adds the error monitor
module abs_diff_sop_pipe
  import abs_diff_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int OUT_W = 2,
  parameter int NPROD = 2,
  parameter logic [NPROD*2*WIDTH-1:0] LPOS = '0,
  parameter logic [NPROD*2*WIDTH-1:0] LNEG = '0,
  parameter logic [NPROD*OUT_W-1:0] ACT = '0,
  parameter int ET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] err_max,
  output logic             err_flag
);
  logic s1_valid, in_fire, s2_load, out_fire;
  logic [NPROD-1:0] prod, s1_prod;
  logic [OUT_W-1:0] or_y;
  assign in_ready = ~out_valid | out_ready | ~s1_valid;
  assign in_fire = in_valid & in_ready;
  assign s2_load = s1_valid & (~out_valid | out_ready);
  assign out_fire = out_valid & out_ready;
  sop_plane #(
    .WIDTH(WIDTH), .OUT_W(OUT_W), .NPROD(NPROD), .LPOS(LPOS), .LNEG(LNEG), .ACT(ACT)
  ) u_plane (
    .x({in_b, in_a}), .prod_q(s1_prod), .prod(prod), .y(or_y)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      s1_valid <= in_fire | (s1_valid & ~s2_load);
      out_valid <= s2_load | (out_valid & ~out_ready);
      if (s2_load) out_data <= or_y;
    end
  end
  always_ff @(posedge clk) begin
    if (in_fire) s1_prod <= prod;
  end
`ifdef ABS_DIFF_ERR_MON_EN
  localparam logic [31:0] ET_W = ET;
  logic [WIDTH-1:0] s1_exact, s2_exact, out_z, err;
  // exact value travels alongside the products so it lines up with out_data
  always_ff @(posedge clk) begin
    if (in_fire) s1_exact <= (in_a > in_b) ? in_a - in_b : in_b - in_a;
    if (s2_load) s2_exact <= s1_exact;
  end
  assign out_z = WIDTH'(out_data);
  assign err = (out_z > s2_exact) ? out_z - s2_exact : s2_exact - out_z;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      err_max <= '0;
      err_flag <= 1'b0;
    end else if (out_fire) begin
      if (32'(err) > ET_W) begin
        err_cnt <= (err_cnt == CNT_SAT) ? err_cnt : err_cnt + CNT_W'(1);
        err_flag <= 1'b1;
      end
      if (err > err_max) err_max <= err;
    end
  end
`else
  assign err_cnt = '0;
  assign err_max = '0;
  assign err_flag = 1'b0;
`endif
endmodule

// File: tb/tb_abs_diff_sop_pipe.sv
// tb_abs_diff_sop_pipe: randomized scoreboard bench for abs_diff_sop_pipe (monitor expectations follow ABS_DIFF_ERR_MON_EN)
module tb_abs_diff_sop_pipe;
  localparam int W = 2, OW = 2, NP = 2, ET = 0;
  localparam logic [7:0] LPOS = 8'b0000_1000;
  localparam logic [7:0] LNEG = 8'b0100_0011;
  localparam logic [3:0] ACT = 4'b1111;
`ifdef ABS_DIFF_ERR_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, err_flag;
  logic [W-1:0] in_a, in_b, err_max;
  logic [OW-1:0] out_data;
  logic [15:0] err_cnt;
  abs_diff_sop_pipe #(
    .WIDTH(W), .OUT_W(OW), .NPROD(NP), .LPOS(LPOS), .LNEG(LNEG), .ACT(ACT), .ET(ET)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_cnt(err_cnt), .err_max(err_max), .err_flag(err_flag)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {int out; int exact;} exp_t;
  exp_t q[$];
  int n_tests, n_fail, m_cnt, m_max, m_flag, run, best_run, prev_ov, prev_or, prev_data;
  // product0 = ~x0&~x1&x3 means a==0 with b[1] set; product1 = ~x2 means b even
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    bit p0, p1;
    p0 = (a == 0) && (b >= 2);
    p1 = (b % 2) == 0;
    e.out = (p0 || p1) ? 3 : 0;
    e.exact = (a > b) ? a - b : b - a;
    return e;
  endfunction
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    int err;
    if (rst) begin
      q.delete();
      m_cnt = 0; m_max = 0; m_flag = 0;
      prev_ov = 0; run = 0;
    end else begin
      check("err_cnt", err_cnt, MON ? m_cnt : 0);
      check("err_max", err_max, MON ? m_max : 0);
      check("err_flag", err_flag, MON ? m_flag : 0);
      check("in_ready", in_ready, (out_ready || q.size() < 2) ? 1 : 0);
      if (prev_ov != 0 && prev_or == 0) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          check("out_data", out_data, e.out);
          err = (e.out > e.exact) ? e.out - e.exact : e.exact - e.out;
          if (err > ET) begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            m_flag = 1;
          end
          if (err > m_max) m_max = err;
        end
        run++;
        if (run > best_run) best_run = run;
      end else run = 0;
      if (in_valid && in_ready) q.push_back(model(in_a, in_b));
      prev_ov = out_valid; prev_or = out_ready; prev_data = out_data;
    end
  end
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int a, input int b);
    in_valid = 1'b1;
    in_a = W'(a);
    in_b = W'(b);
    sync();
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int k;
    in_valid = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((q.size() != 0 || out_valid) && k < 50) begin
      sync();
      k++;
    end
    check("drain_empty", q.size(), 0);
  endtask
  task automatic single(input int a, input int b, input int exp_out, input int e_cnt, input int e_max);
    drive(a, b);
    @(negedge clk);
    check("lat1_valid", out_valid, 0);
    @(negedge clk);
    check("lat2_valid", out_valid, 1);
    check("lat2_data", out_data, exp_out);
    @(negedge clk);
    check("dir_cnt", err_cnt, MON ? e_cnt : 0);
    check("dir_max", err_max, MON ? e_max : 0);
    check("dir_flag", err_flag, MON ? 1 : 0);
    sync();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    n_tests = 0; n_fail = 0; best_run = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    sync();
    single(0, 2, 3, 1, 1);
    // a==b==0 gives out 3 against exact 0: worst-case error
    single(0, 0, 3, 2, 3);
    best_run = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_a = W'($urandom);
      in_b = W'($urandom);
      sync();
    end
    drain();
    check("b2b_run", best_run, 8);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a = W'($urandom);
      in_b = W'($urandom);
      sync();
    end
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = W'($urandom);
      in_b = W'($urandom);
      sync();
    end
    drain();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      sync();
    end
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = W'($urandom);
      in_b = 2'd2;
      sync();
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_err_cnt", err_cnt, 0);
    check("arst_err_max", err_max, 0);
    check("arst_err_flag", err_flag, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    sync();
    rst = 1'b0;
    sync();
    check("post_rst_out_valid", out_valid, 0);
`ifdef ABS_DIFF_ERR_MON_EN
    force dut.err_cnt = 16'hFFFE;
    m_cnt = 'hFFFE;
    sync();
    release dut.err_cnt;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = '0;
      in_b = '0;
      sync();
    end
    drain();
    sync();
    check("sat_err_cnt", err_cnt, 'hFFFF);
`endif
    sync();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
